// File: rtl/iddr_align_pkg.sv
// iddr_align_pkg: shared state encoding and width helpers for the IDDR word aligner
package iddr_align_pkg;
  typedef enum logic [2:0] {IDLE, HUNT, SETTLE, VERIFY, LOCK, FAIL} state_e;
  localparam int MC_W = 8;
  function automatic int sp_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/iddr_gearbox.sv
// iddr_gearbox: collects IDDR bit pairs into a 2-word window and strobes a word candidate
module iddr_gearbox
  import iddr_align_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      q1_i,
  input  logic                      q2_i,
  input  logic [sp_w(WORD_W)-1:0]   slip_pos_i,
  output logic [WORD_W-1:0]         cand_o,
  output logic                      stb_o
);
  localparam int PHW = sp_w(WORD_W / 2);
  localparam logic [PHW-1:0] PH_END = PHW'(WORD_W / 2 - 1);
  logic [2*WORD_W-1:0] sr_q;
  logic [PHW-1:0]      ph_q;
  assign stb_o  = ph_q == PH_END;
  assign cand_o = sr_q[slip_pos_i +: WORD_W];
  // shift in Q1 (older) then Q2 every cycle and count pairs per word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
      ph_q <= '0;
    end else begin
      sr_q <= {sr_q[2*WORD_W-3:0], q1_i, q2_i};
      ph_q <= stb_o ? '0 : ph_q + 1'b1;
    end
  end
endmodule

// File: rtl/iddr_word_aligner.sv
// iddr_word_aligner: IDDR training/bit-slip aligner; IDDR_ALIGN_SLIPCNT_EN adds SLIP_TOTAL
module iddr_word_aligner
  import iddr_align_pkg::*;
#(
  parameter int          WORD_W    = 8,
  parameter logic [15:0] TRAIN_PAT = 16'hB8,
  parameter int          LOCK_CNT  = 16,
  parameter int          SLIP_WAIT = 2
) (
  input  logic                      C,
  input  logic                      R,
  input  logic                      Q1,
  input  logic                      Q2,
  input  logic                      TRAIN,
  output logic [WORD_W-1:0]         WORD,
  output logic                      WORD_VLD,
  output logic                      LOCKED,
  output logic                      ERR,
`ifdef IDDR_ALIGN_SLIPCNT_EN
  output logic [15:0]               SLIP_TOTAL,
`endif
  output logic [sp_w(WORD_W)-1:0]   SLIP_POS
);
  localparam int SPW = sp_w(WORD_W);
  localparam int SWW = SPW + 1;
  localparam logic [SPW-1:0]  SP_MAX = SPW'(WORD_W - 1);
  localparam logic [SWW-1:0]  SW_END = SWW'(WORD_W);
  localparam logic [MC_W-1:0] MC_END = MC_W'(LOCK_CNT);
  localparam logic [2:0]      WT_END = 3'(SLIP_WAIT);
  state_e              st_q;
  logic [WORD_W-1:0]   cand, word_q;
  logic                stb, match, slip, vld_q, lock_q, err_q;
  logic [SPW-1:0]      sp_q, sp_d;
  logic [SWW-1:0]      sw_q, sw_d;
  logic [MC_W-1:0]     mc_q, mc_d;
  logic [2:0]          wc_q;
  iddr_gearbox #(.WORD_W(WORD_W)) u_gearbox (
    .clk_i      (C),
    .rst_i      (R),
    .q1_i       (Q1),
    .q2_i       (Q2),
    .slip_pos_i (sp_q),
    .cand_o     (cand),
    .stb_o      (stb)
  );
  // a slip happens on a strobed mismatch while hunting or verifying, unless TRAIN overrides it
  always_comb begin
    match = cand == TRAIN_PAT[WORD_W-1:0];
    slip  = stb && !TRAIN && (st_q == HUNT || st_q == VERIFY) && !match;
    sp_d  = (sp_q == SP_MAX) ? '0 : sp_q + 1'b1;
    sw_d  = sw_q + 1'b1;
    mc_d  = mc_q + 1'b1;
  end
  // training FSM with registered word/strobe/lock/error outputs; TRAIN beats any strobe
  always_ff @(posedge C) begin
    if (R) begin
      st_q   <= IDLE;
      sp_q   <= '0;
      sw_q   <= '0;
      mc_q   <= '0;
      wc_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= stb;
      if (stb) word_q <= cand;
      if (TRAIN) begin
        st_q   <= HUNT;
        sw_q   <= '0;
        mc_q   <= '0;
        wc_q   <= '0;
        lock_q <= 1'b0;
        err_q  <= 1'b0;
      end else if (slip) begin
        sp_q  <= sp_d;
        sw_q  <= sw_d;
        mc_q  <= '0;
        wc_q  <= '0;
        st_q  <= (sw_d == SW_END) ? FAIL : SETTLE;
        err_q <= sw_d == SW_END;
      end else if (stb && (st_q == HUNT || st_q == VERIFY)) begin
        mc_q   <= mc_d;
        st_q   <= (mc_d == MC_END) ? LOCK : VERIFY;
        lock_q <= mc_d == MC_END;
      end else if (stb && st_q == SETTLE) begin
        wc_q <= (wc_q == WT_END) ? '0 : wc_q + 1'b1;
        st_q <= (wc_q == WT_END) ? HUNT : SETTLE;
      end
    end
  end
`ifdef IDDR_ALIGN_SLIPCNT_EN
  logic [15:0] tot_q;
  // lifetime slip count, saturating, survives TRAIN
  always_ff @(posedge C) begin
    if (R) tot_q <= '0;
    else if (slip && tot_q != 16'hFFFF) tot_q <= tot_q + 1'b1;
  end
  assign SLIP_TOTAL = tot_q;
`endif
  assign WORD     = word_q;
  assign WORD_VLD = vld_q;
  assign LOCKED   = lock_q;
  assign ERR      = err_q;
  assign SLIP_POS = sp_q;
endmodule

// File: tb/tb_iddr_word_aligner.sv
// tb_iddr_word_aligner: directed bench with word scoreboard for iddr_word_aligner
module tb_iddr_word_aligner;
  logic C = 1'b0, R = 1'b1, Q1 = 1'b0, Q2 = 1'b0, TRAIN = 1'b0;
  logic [7:0] WORD;
  logic       WORD_VLD, LOCKED, ERR;
  logic [2:0] SLIP_POS;
`ifdef IDDR_ALIGN_SLIPCNT_EN
  logic [15:0] SLIP_TOTAL;
`endif
  int checks = 0, errors = 0;
  logic [7:0] pat = 8'h00;
  int         shf = 3;
  int         mph = 0, nbit = 0;
  logic       mstb = 1'b0, exp_on = 1'b0;
  logic [7:0] exp_word = 8'h00;
  logic [7:0] sb[$];

  iddr_word_aligner #(.WORD_W(8), .TRAIN_PAT(16'hB8), .LOCK_CNT(4), .SLIP_WAIT(2)) dut (
    .C(C), .R(R), .Q1(Q1), .Q2(Q2), .TRAIN(TRAIN),
    .WORD(WORD), .WORD_VLD(WORD_VLD), .LOCKED(LOCKED), .ERR(ERR),
`ifdef IDDR_ALIGN_SLIPCNT_EN
    .SLIP_TOTAL(SLIP_TOTAL),
`endif
    .SLIP_POS(SLIP_POS)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stream bit n: pattern MSB-first, rotated so it starts at bit shf
  function automatic logic bitv(input int n);
    int idx;
    idx = ((n - shf) % 8 + 8) % 8;
    return pat[7 - idx];
  endfunction

  // one clock: drive the next pair, model the phase counter, score the word
  task automatic tick();
    Q1 = bitv(nbit);
    Q2 = bitv(nbit + 1);
    mstb = (mph == 3) && !R;
    if (mstb && exp_on) sb.push_back(exp_word);
    @(posedge C);
    #1;
    if (R) begin
      mph = 0;
      nbit = 0;
    end else begin
      mph = (mph + 1) % 4;
      nbit += 2;
    end
    chk("word_vld", 32'(WORD_VLD), 32'(mstb));
    if (WORD_VLD && sb.size() > 0) chk("word", 32'(WORD), 32'(sb.pop_front()));
  endtask

  task automatic pulse_train();
    TRAIN = 1'b1;
    tick();
    TRAIN = 1'b0;
  endtask

  initial begin
    int n;
    R = 1'b1;
    repeat (3) tick();
    chk("rst_word", 32'(WORD), 32'd0);
    chk("rst_locked", 32'(LOCKED), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_slip", 32'(SLIP_POS), 32'd0);
    R = 1'b0;
    // 1: idle with zero input, strobe cadence and zero words
    exp_on = 1'b1;
    exp_word = 8'h00;
    repeat (20) tick();
    exp_on = 1'b0;
    chk("idle_locked", 32'(LOCKED), 32'd0);
    chk("idle_err", 32'(ERR), 32'd0);
    chk("idle_slip", 32'(SLIP_POS), 32'd0);
    // 2: pattern at offset 3, train and lock
    pat = 8'hB8;
    shf = 3;
    repeat (16) tick();
    pulse_train();
    n = 0;
    while (!LOCKED && n < 400) begin tick(); n++; end
    chk("s2_locked", 32'(LOCKED), 32'd1);
    chk("s2_slip", 32'(SLIP_POS), 32'd3);
    chk("s2_err", 32'(ERR), 32'd0);
    exp_on = 1'b1;
    exp_word = 8'hB8;
    repeat (24) tick();
    exp_on = 1'b0;
    // 3: all-zero stream exhausts the sweep
    pat = 8'h00;
    repeat (16) tick();
    chk("s3_lock_hold", 32'(LOCKED), 32'd1);
    pulse_train();
    chk("s3_unlock", 32'(LOCKED), 32'd0);
    n = 0;
    while (!ERR && n < 600) begin tick(); n++; end
    chk("s3_err", 32'(ERR), 32'd1);
    chk("s3_locked", 32'(LOCKED), 32'd0);
    chk("s3_slip_wrap", 32'(SLIP_POS), 32'd3);
    pat = 8'hB8;
    shf = 3;
    repeat (16) tick();
    chk("s3_err_sticky", 32'(ERR), 32'd1);
    pulse_train();
    chk("s3_err_clr", 32'(ERR), 32'd0);
    n = 0;
    while (!LOCKED && n < 400) begin tick(); n++; end
    chk("s3_relock", 32'(LOCKED), 32'd1);
    chk("s3_relock_slip", 32'(SLIP_POS), 32'd3);
    // 4: one-bit stream shift, retrain moves the boundary by one
    shf = 2;
    repeat (16) tick();
    pulse_train();
    chk("s4_unlock", 32'(LOCKED), 32'd0);
    n = 0;
    while (!LOCKED && n < 400) begin tick(); n++; end
    chk("s4_locked", 32'(LOCKED), 32'd1);
    chk("s4_slip", 32'(SLIP_POS), 32'd4);
    exp_on = 1'b1;
    exp_word = 8'hB8;
    repeat (16) tick();
    exp_on = 1'b0;
    // 5: reset while verifying with two matches counted
    n = 0;
    while (mph != 0 && n < 8) begin tick(); n++; end
    pulse_train();
    n = 0;
    while (n < 2) begin tick(); if (mstb) n++; end
    chk("s5_verify_unlocked", 32'(LOCKED), 32'd0);
    chk("s5_verify_slip", 32'(SLIP_POS), 32'd4);
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("s5_rst_word", 32'(WORD), 32'd0);
    chk("s5_rst_locked", 32'(LOCKED), 32'd0);
    chk("s5_rst_err", 32'(ERR), 32'd0);
    chk("s5_rst_slip", 32'(SLIP_POS), 32'd0);
    R = 1'b1;
    TRAIN = 1'b1;
    tick();
    R = 1'b0;
    TRAIN = 1'b0;
    repeat (60) tick();
    chk("s5_idle_slip", 32'(SLIP_POS), 32'd0);
    chk("s5_idle_locked", 32'(LOCKED), 32'd0);
`ifdef IDDR_ALIGN_SLIPCNT_EN
    // 6: two failed sweeps accumulate, TRAIN does not clear the total
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("s6_rst_total", 32'(SLIP_TOTAL), 32'd0);
    pat = 8'h00;
    repeat (16) tick();
    pulse_train();
    n = 0;
    while (!ERR && n < 600) begin tick(); n++; end
    chk("s6_err1", 32'(ERR), 32'd1);
    pulse_train();
    chk("s6_total_kept", 32'(SLIP_TOTAL), 32'd8);
    n = 0;
    while (!ERR && n < 600) begin tick(); n++; end
    chk("s6_err2", 32'(ERR), 32'd1);
    chk("s6_total", 32'(SLIP_TOTAL), 32'd16);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
